imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arb_pkg.sv | 41 ++++
 rtl/imem_arb_pick.sv | 42 ++++
 rtl/imem_arbiter.sv | 146 ++++++++++++++
 tb/tb_imem_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and field layout for the instruction-memory arbiter.
// Instruction word: operand [10:3], opcode [2:0].
package imem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RMW_RD,
    S_RMW_WR,
    S_LD_WR
  } state_t;

  // Encoding doubles as the bit index into the request vector.
  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_WB = 2'd1,
    REQ_FE = 2'd2
  } req_id_t;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 2;
  localparam int OPND_LSB = 3;
  localparam int OPND_MSB = 10;

  function automatic req_id_t rr_next(input req_id_t id);
    case (id)
      REQ_LD:  return REQ_WB;
      REQ_WB:  return REQ_FE;
      default: return REQ_LD;
    endcase
  endfunction

  function automatic req_id_t rr_prev(input req_id_t id);
    case (id)
      REQ_WB:  return REQ_LD;
      REQ_FE:  return REQ_WB;
      default: return REQ_FE;
    endcase
  endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Requester selection. IMEM_ARB_RR_EN selects round-robin (loader, writeback,
// fetch); otherwise fixed priority loader > writeback > fetch.
module imem_arb_pick
  import imem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  req_id_t    last_i,
  output req_id_t    gnt_id_o,
  output logic       gnt_vld_o
);

`ifdef IMEM_ARB_RR_EN
  always_comb begin
    req_id_t cand;
    logic    found;
    gnt_id_o  = REQ_LD;
    gnt_vld_o = 1'b0;
    found     = 1'b0;
    cand      = rr_next(last_i);
    for (int k = 0; k < 3; k++) begin
      if (!found && req_i[cand]) begin
        gnt_id_o  = cand;
        gnt_vld_o = 1'b1;
        found     = 1'b1;
      end
      cand = rr_next(cand);
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_id_o  = REQ_LD;
    gnt_vld_o = |req_i;
    if (req_i[REQ_LD])      gnt_id_o = REQ_LD;
    else if (req_i[REQ_WB]) gnt_id_o = REQ_WB;
    else if (req_i[REQ_FE]) gnt_id_o = REQ_FE;
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Serialises fetch, operand writeback (read-modify-write) and loader writes
// onto a single synchronous-read instruction memory. Option: IMEM_ARB_RR_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 11,
  parameter int OPND_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [OPND_W-1:0] w_operand,
  output logic              w_gnt,
  output logic              w_done,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q;
  req_id_t           prio_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] ld_data_q;
  logic [DATA_W-1:0] rdata_hold_q;
  logic [OPND_W-1:0] opnd_q;
  logic              f_gnt_q, w_gnt_q, l_gnt_q;
  logic              f_rvalid_q, w_done_q;
  logic              mem_en_q, mem_we_q;

  logic [2:0]        req_vec;
  req_id_t           last_id;
  req_id_t           pick_id;
  logic              pick_vld;
  logic [DATA_W-1:0] rmw_word;

  assign req_vec = {f_req, w_req, l_req};
  assign last_id = rr_prev(prio_q);

  imem_arb_pick u_pick (
    .req_i     (req_vec),
    .last_i    (last_id),
    .gnt_id_o  (pick_id),
    .gnt_vld_o (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= REQ_LD;
      mem_addr_q   <= '0;
      ld_data_q    <= '0;
      rdata_hold_q <= '0;
      opnd_q       <= '0;
      f_gnt_q      <= 1'b0;
      w_gnt_q      <= 1'b0;
      l_gnt_q      <= 1'b0;
      f_rvalid_q   <= 1'b0;
      w_done_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      f_gnt_q    <= 1'b0;
      w_gnt_q    <= 1'b0;
      l_gnt_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      f_rvalid_q <= (state_q == S_FETCH);
      w_done_q   <= (state_q == S_RMW_WR);
      if (f_rvalid_q) rdata_hold_q <= mem_rdata;

      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            prio_q   <= rr_next(pick_id);
            mem_en_q <= 1'b1;
            case (pick_id)
              REQ_LD: begin
                state_q    <= S_LD_WR;
                mem_addr_q <= l_addr;
                ld_data_q  <= l_wdata;
                l_gnt_q    <= 1'b1;
                mem_we_q   <= 1'b1;
              end
              REQ_WB: begin
                state_q    <= S_RMW_RD;
                mem_addr_q <= w_addr;
                opnd_q     <= w_operand;
                w_gnt_q    <= 1'b1;
              end
              default: begin
                state_q    <= S_FETCH;
                mem_addr_q <= f_addr;
                f_gnt_q    <= 1'b1;
              end
            endcase
          end
        end
        // Read half done; write back to the same address next cycle.
        S_RMW_RD: begin
          state_q  <= S_RMW_WR;
          mem_en_q <= 1'b1;
          mem_we_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Opcode comes straight from the read issued in RMW_RD, so this merge
  // cannot be registered ahead of the write cycle.
  always_comb begin
    rmw_word                   = '0;
    rmw_word[OPND_MSB:OPND_LSB] = opnd_q;
    rmw_word[OPC_MSB:OPC_LSB]   = mem_rdata[OPC_MSB:OPC_LSB];
  end

  always_comb begin
    mem_wdata = '0;
    if (state_q == S_RMW_WR)     mem_wdata = rmw_word;
    else if (state_q == S_LD_WR) mem_wdata = ld_data_q;
  end

  assign f_rdata  = f_rvalid_q ? mem_rdata : rdata_hold_q;
  assign f_gnt    = f_gnt_q;
  assign f_rvalid = f_rvalid_q;
  assign w_gnt    = w_gnt_q;
  assign w_done   = w_done_q;
  assign l_gnt    = l_gnt_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter against a transaction-level
// model (expected grant order, latencies and memory image).
module tb_imem_arbiter;

  localparam int AW = 10;
  localparam int DW = 11;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, w_req, l_req;
  logic [AW-1:0] f_addr, w_addr, l_addr;
  logic [OW-1:0] w_operand;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, w_gnt, w_done, l_gnt;
  logic [DW-1:0] f_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OPND_W(OW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_operand(w_operand), .w_gnt(w_gnt), .w_done(w_done),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  logic [DW-1:0] shadow [0:15];
  int n_vec = 0;
  int n_err = 0;
  int ptr   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester ids: 0 loader, 1 writeback, 2 fetch.
  function automatic int model_pick(input logic [2:0] pend);
    for (int k = 0; k < 3; k++) begin
      int id;
`ifdef IMEM_ARB_RR_EN
      id = (ptr + k) % 3;
`else
      id = k;
`endif
      if (pend[id]) return id;
    end
    return -1;
  endfunction

  // Called just after a negedge with the arbiter idle; returns at the first
  // idle cycle after all requests are served.
  task automatic run_round(input logic [2:0] en, input logic [3:0] la, input logic [DW-1:0] ld,
                           input logic [3:0] wa, input logic [OW-1:0] wo, input logic [3:0] fa);
    logic [2:0]    pend;
    logic [2:0]    g;
    logic [DW-1:0] fe_exp;
    int t, next_t, fe_t, wb_t, wbw_t, w;
    pend = en; t = 0; next_t = 1; fe_t = -1; wb_t = -1; wbw_t = -1; fe_exp = '0;
    l_req = en[0]; l_addr = {6'd0, la}; l_wdata = ld;
    w_req = en[1]; w_addr = {6'd0, wa}; w_operand = wo;
    f_req = en[2]; f_addr = {6'd0, fa};
    while (1) begin
      @(negedge clk);
      t++;
      w = (pend != 3'b000 && t == next_t) ? model_pick(pend) : -1;
      g = 3'b000;
      if (w >= 0) g[w] = 1'b1;
      chk("grant", {29'd0, f_gnt, w_gnt, l_gnt}, {29'd0, g});
      chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, (t == fe_t)});
      if (t == fe_t) chk("f_rdata", {21'd0, f_rdata}, {21'd0, fe_exp});
      chk("w_done", {31'd0, w_done}, {31'd0, (t == wb_t)});
      chk("mem_en", {31'd0, mem_en}, {31'd0, (w >= 0) || (t == wbw_t)});
      chk("mem_we", {31'd0, mem_we}, {31'd0, (w == 0) || (t == wbw_t)});
      if (w >= 0) begin
        case (w)
          0: begin
            chk("ld_addr", {22'd0, mem_addr}, {28'd0, la});
            chk("ld_wdata", {21'd0, mem_wdata}, {21'd0, ld});
            shadow[la] = ld;
            l_req = 1'b0; l_addr = AW'($urandom); l_wdata = DW'($urandom);
          end
          1: begin
            chk("wb_addr", {22'd0, mem_addr}, {28'd0, wa});
            wbw_t = t + 1; wb_t = t + 2;
            shadow[wa] = {wo, shadow[wa][2:0]};
            w_req = 1'b0; w_addr = AW'($urandom); w_operand = OW'($urandom);
          end
          default: begin
            chk("fe_addr", {22'd0, mem_addr}, {28'd0, fa});
            fe_t = t + 1; fe_exp = shadow[fa];
            f_req = 1'b0; f_addr = AW'($urandom);
          end
        endcase
        pend[w] = 1'b0;
`ifdef IMEM_ARB_RR_EN
        ptr = (w + 1) % 3;
`endif
        next_t = t + ((w == 1) ? 3 : 2);
      end
      if (pend == 3'b000 && t >= next_t - 1) break;
      if (t > 40) begin
        chk("round_timeout", t, 0);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    f_req = 1'b0; w_req = 1'b0; l_req = 1'b0;
    f_addr = '0; w_addr = '0; l_addr = '0; w_operand = '0; l_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pulses", {26'd0, f_gnt, f_rvalid, w_gnt, w_done, l_gnt, mem_en}, 32'd0);
    chk("rst_data", {mem_we, f_rdata, mem_addr, 10'd0}, 32'd0);
    chk("rst_wdata", {21'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    ptr = 0;

    for (int a = 0; a < 16; a++) run_round(3'b001, 4'(a), DW'($urandom), 4'd0, 8'd0, 4'd0);

    // Loader then fetch of the same word.
    run_round(3'b001, 4'd5, 11'h02B, 4'd0, 8'd0, 4'd0);
    run_round(3'b100, 4'd0, 11'd0, 4'd0, 8'd0, 4'd5);
    chk("ld_mem5", {21'd0, mem[5]}, 32'h02B);

    // Operand writeback keeps the opcode.
    run_round(3'b001, 4'd7, 11'h031, 4'd0, 8'd0, 4'd0);
    run_round(3'b010, 4'd0, 11'd0, 4'd7, 8'h66, 4'd0);
    chk("wb_mem7", {21'd0, mem[7]}, 32'h331);

    // All three at once, twice (rotation visible in round-robin builds).
    run_round(3'b111, 4'd1, DW'($urandom), 4'd2, OW'($urandom), 4'd3);
    run_round(3'b111, 4'd10, DW'($urandom), 4'd11, OW'($urandom), 4'd12);

    // Reset while the writeback is in its read half.
    w_req = 1'b1; w_addr = 10'd4; w_operand = 8'h5A;
    @(negedge clk);
    chk("rst_rmw_wgnt", {31'd0, w_gnt}, 32'd1);
    w_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rmw_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_rmw_outs", {26'd0, f_gnt, f_rvalid, w_gnt, w_done, l_gnt, mem_en}, 32'd0);
    rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rmw_idle", {29'd0, w_done, mem_en, mem_we}, 32'd0);
    end
    chk("rst_rmw_mem4", {21'd0, mem[4]}, {21'd0, shadow[4]});

    // Writeback and fetch to the same word queued together.
    run_round(3'b110, 4'd0, 11'd0, 4'd9, 8'hC3, 4'd9);
    chk("wb_fe_mem9", {21'd0, mem[9]}, {21'd0, shadow[9]});

    repeat (150) begin
      run_round(3'($urandom_range(1, 7)), 4'($urandom), DW'($urandom),
                4'($urandom), OW'($urandom), 4'($urandom));
    end

    for (int a = 0; a < 16; a++) chk("mem_image", {21'd0, mem[a]}, {21'd0, shadow[a]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
